// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sweep decoder: FSM state encoding and a
// width-bounded one-hot helper.
package decoder_pkg;

  localparam int unsigned MAX_OUT_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One-hot of sel within a vector of the given width; all-zero when sel is out of range.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned sel,
                                                  input int unsigned width);
    logic [MAX_OUT_W-1:0] v;
    v = MAX_OUT_W'(1) << sel;
    if (sel >= width) v = '0;
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable; output is all-zero when
// the enable is low.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 5
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [(2**SEL_W)-1:0] dec
);

  localparam int unsigned OUT_W = 2**SEL_W;

  always_comb begin
    dec = '0;
    if (en) dec = OUT_W'(onehot(32'(sel), OUT_W));
  end

endmodule

// File: rtl/sweep_decoder.sv
// Registered one-hot decoder with a one-shot sweep that walks every output
// (optionally skipping the top one) and pulses done when finished.
module sweep_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W    = 5,
  parameter bit          SKIP_TOP = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      in,
  input  logic                  en,
  input  logic                  sweep_start,
  output logic [(2**SEL_W)-1:0] out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned OUT_W    = 2**SEL_W;
  localparam int unsigned LAST     = SKIP_TOP ? OUT_W - 2 : OUT_W - 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LAST);

  state_t           state, state_d;
  logic [SEL_W-1:0] cnt, cnt_d;
  logic [SEL_W-1:0] dec_sel_c;
  logic             dec_en_c;
  logic [OUT_W-1:0] dec_c;
  logic [OUT_W-1:0] out_d;
  logic             busy_d, done_d;

  // Select mux shared by the normal-decode and sweep paths
  always_comb begin
    dec_sel_c = in;
    dec_en_c  = 1'b0;
    case (state)
      IDLE: begin
        dec_sel_c = sweep_start ? '0 : in;
        dec_en_c  = sweep_start | en;
      end
      SWEEP: begin
        dec_sel_c = cnt;
        dec_en_c  = 1'b1;
      end
      default: ;
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel (dec_sel_c),
    .en  (dec_en_c),
    .dec (dec_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      out   <= out_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Next-state logic; the sweep ends once the displayed bit reaches LAST
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (sweep_start) state_d = SWEEP;
      SWEEP:   if (out[LAST])   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next register values; cnt saturates at LAST so it never wraps
  always_comb begin
    out_d  = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    cnt_d  = cnt;
    case (state)
      IDLE: begin
        out_d = dec_c;
        if (sweep_start) begin
          busy_d = 1'b1;
          cnt_d  = SEL_W'(1);
        end
      end
      SWEEP: begin
        if (out[LAST]) begin
          done_d = 1'b1;
          cnt_d  = '0;
        end else begin
          out_d  = dec_c;
          busy_d = 1'b1;
          cnt_d  = (cnt == LAST_SEL) ? cnt : cnt + SEL_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sweep_decoder.sv
// Bench for sweep_decoder: directed scenarios plus random traffic on a 32-output
// instance (top skipped) and a 4-output instance (no skip), against a position model.
module tb_sweep_decoder;

  logic        clk;
  logic        reset;
  logic [4:0]  in;
  logic        en;
  logic        sweep_start;
  logic [31:0] out0;
  logic        busy0, done0;
  logic [3:0]  out1;
  logic        busy1, done1;

  int errors = 0;
  int checks = 0;

  // Model: pos = -1 idle, 0..last sweeping (shows bit pos), last+1 done cycle
  int          m_pos  [2];
  logic [31:0] m_out  [2];
  logic        m_busy [2];
  logic        m_done [2];

  sweep_decoder #(.SEL_W(5), .SKIP_TOP(1'b1)) dut0 (
    .clk(clk), .reset(reset), .in(in), .en(en), .sweep_start(sweep_start),
    .out(out0), .busy(busy0), .done(done0)
  );

  sweep_decoder #(.SEL_W(2), .SKIP_TOP(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in(in[1:0]), .en(en), .sweep_start(sweep_start),
    .out(out1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k, input int last, input int outw,
                            input logic r, input int sel, input logic e, input logic s);
    if (r) begin
      m_pos[k] = -1; m_out[k] = '0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
    end else if (m_pos[k] == -1) begin
      m_done[k] = 1'b0;
      if (s) begin
        m_pos[k] = 0; m_out[k] = 32'd1; m_busy[k] = 1'b1;
      end else begin
        m_out[k]  = e ? (32'd1 << (sel % outw)) : 32'd0;
        m_busy[k] = 1'b0;
      end
    end else if (m_pos[k] < last) begin
      m_pos[k]++;
      m_out[k]  = 32'd1 << m_pos[k];
      m_busy[k] = 1'b1;
    end else if (m_pos[k] == last) begin
      m_pos[k]  = last + 1;
      m_out[k]  = '0; m_busy[k] = 1'b0; m_done[k] = 1'b1;
    end else begin
      m_pos[k]  = -1;
      m_out[k]  = '0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
    end
  endtask

  task automatic cycle(input logic r, input logic [4:0] i, input logic e, input logic s);
    reset = r; in = i; en = e; sweep_start = s;
    @(posedge clk);
    model_step(0, 30, 32, r, int'(i), e, s);
    model_step(1, 3, 4, r, int'(i), e, s);
    #1;
    chk("out0",  out0,          m_out[0]);
    chk("busy0", 32'(busy0),    32'(m_busy[0]));
    chk("done0", 32'(done0),    32'(m_done[0]));
    chk("out1",  {28'd0, out1}, m_out[1]);
    chk("busy1", 32'(busy1),    32'(m_busy[1]));
    chk("done1", 32'(done1),    32'(m_done[1]));
  endtask

  initial begin
    int   bcount;
    logic seen_done;
    logic seen_b31;

    for (int k = 0; k < 2; k++) begin
      m_pos[k] = -1; m_out[k] = '0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
    end
    reset = 1'b1; in = '0; en = 1'b0; sweep_start = 1'b0;

    // Reset overrides active inputs
    cycle(1'b1, 5'd3, 1'b1, 1'b1);
    cycle(1'b1, 5'd3, 1'b1, 1'b1);
    chk("reset_out", out0, 32'h0);
    chk("reset_busy", 32'(busy0), 32'h0);

    // Normal decode
    cycle(1'b0, 5'd3, 1'b1, 1'b0);
    chk("dec_in3", out0, 32'h0000_0008);
    cycle(1'b0, 5'd3, 1'b0, 1'b0);
    chk("dec_en0", out0, 32'h0);
    cycle(1'b0, 5'd31, 1'b1, 1'b0);
    chk("dec_top", out0, 32'h8000_0000);
    chk("dec_top_small", {28'd0, out1}, 32'h8);

    // Sweep wins over en; second start mid-sweep is ignored
    cycle(1'b0, 5'd7, 1'b1, 1'b1);
    chk("sweep_first", out0, 32'h1);
    bcount = busy0 ? 1 : 0;
    seen_done = 1'b0;
    seen_b31 = 1'b0;
    for (int n = 0; n < 60 && !seen_done; n++) begin
      cycle(1'b0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), (n == 8) ? 1'b1 : 1'b0);
      if (busy0) bcount++;
      if (out0[31]) seen_b31 = 1'b1;
      if (done0) begin
        seen_done = 1'b1;
        chk("done_out_zero", out0, 32'h0);
      end
    end
    chk("sweep_done_seen", 32'(seen_done), 32'h1);
    chk("sweep_busy_cnt", 32'(bcount), 32'd31);
    chk("sweep_no_bit31", 32'(seen_b31), 32'h0);
    cycle(1'b0, 5'd0, 1'b0, 1'b0);
    chk("done_pulse_one", 32'(done0), 32'h0);

    // Small instance without skip walks all four outputs
    cycle(1'b0, 5'd0, 1'b0, 1'b1);
    chk("small_w0", {28'd0, out1}, 32'h1);
    cycle(1'b0, 5'd0, 1'b0, 1'b0);
    chk("small_w1", {28'd0, out1}, 32'h2);
    cycle(1'b0, 5'd0, 1'b0, 1'b0);
    chk("small_w2", {28'd0, out1}, 32'h4);
    cycle(1'b0, 5'd0, 1'b0, 1'b0);
    chk("small_w3", {28'd0, out1}, 32'h8);
    chk("small_busy", 32'(busy1), 32'h1);
    cycle(1'b0, 5'd0, 1'b0, 1'b0);
    chk("small_done", 32'(done1), 32'h1);
    chk("small_busy_off", 32'(busy1), 32'h0);

    seen_done = 1'b0;
    for (int n = 0; n < 40 && !seen_done; n++) begin
      cycle(1'b0, 5'd0, 1'b0, 1'b0);
      if (done0) seen_done = 1'b1;
    end
    chk("wide_done_after_small", 32'(seen_done), 32'h1);
    cycle(1'b0, 5'd0, 1'b0, 1'b0);

    // Reset at sweep cycle 12 aborts without a done pulse
    cycle(1'b0, 5'd0, 1'b0, 1'b1);
    for (int n = 0; n < 11; n++) cycle(1'b0, 5'd0, 1'b0, 1'b0);
    chk("mid_out", out0, 32'h0000_0800);
    cycle(1'b1, 5'd0, 1'b0, 1'b0);
    chk("abort_out", out0, 32'h0);
    chk("abort_busy", 32'(busy0), 32'h0);
    chk("abort_done", 32'(done0), 32'h0);
    seen_done = 1'b0;
    for (int n = 0; n < 35; n++) begin
      cycle(1'b0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
      if (done0) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sweep_decoder.md
SWEEP_DECODER -- requirements
Module: sweep_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 5, select width in bits, legal range 1..6.
REQ-002 SHALL have parameter SKIP_TOP, default 1, exclude the highest output from sweeps when 1 (hard-wired zero register).
REQ-003 SHALL have derived constant OUT_W = 2**SEL_W, the number of decoded outputs.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port in, input, SEL_W bits, binary select for normal decode.
REQ-007 SHALL have port en, input, 1 bit, normal-decode enable.
REQ-008 SHALL have port sweep_start, input, 1 bit, request to walk all outputs once (clear sequence).
REQ-009 SHALL have port out, output, OUT_W bits, registered one-hot or all-zero decode.
REQ-010 SHALL have port busy, output, 1 bit, high while a sweep is in progress.
REQ-011 SHALL have port done, output, 1 bit, one-cycle pulse at the end of a sweep.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, SWEEP and DONE.
REQ-013 In IDLE with sweep_start=0, the next out SHALL be onehot(in) if en=1, else all zeros; latency is exactly 1 cycle.
REQ-014 SHALL raise at most one bit of out in any cycle.
REQ-015 In IDLE with sweep_start=1, the next state SHALL be SWEEP, with out<=onehot(0), busy<=1 and cnt<=1; sweep_start takes priority over en in the same cycle.
REQ-016 Define LAST = OUT_W-2 if SKIP_TOP=1, else OUT_W-1.
REQ-017 In SWEEP, each edge SHALL set out<=onehot(cnt) and cnt<=cnt+1 while the out bit currently shown is below LAST.
REQ-018 When out shows bit LAST, the next edge SHALL set out<=0, busy<=0 and done<=1, and move to DONE.
REQ-019 In DONE, the next edge SHALL set done<=0 and move to IDLE; out SHALL follow REQ-013 from that edge.
REQ-020 busy SHALL be high for exactly LAST+1 cycles per sweep; bit OUT_W-1 is never asserted in a sweep when SKIP_TOP=1.
REQ-021 en, in and sweep_start SHALL be ignored in SWEEP and DONE; a start request is neither queued nor restarted.
REQ-022 Normal decode SHALL still assert bit OUT_W-1 when in=OUT_W-1 and en=1, regardless of SKIP_TOP.
REQ-023 cnt SHALL be SEL_W bits wide and SHALL never wrap; termination is by compare to LAST.
REQ-024 The design SHALL contain no combinational path from any input to any output.

Reset
REQ-025 On reset=1 at an edge, the design SHALL set state=IDLE, out=0, busy=0, done=0 and cnt=0, overriding all other inputs.
REQ-026 Reset asserted mid-sweep SHALL abort it with no done pulse; the first edge after reset deasserts SHALL behave as IDLE.

Structure
REQ-027 The state enum and a onehot(sel, width) function SHALL live in shared package decoder_pkg.
REQ-028 The combinational decode SHALL be sub-module onehot_dec (parameter SEL_W) and SHALL be shared by the normal and sweep paths through an input mux on the select.

Verification
REQ-029 With SEL_W=5, SKIP_TOP=1, en=1 and in=3, out SHALL be 0x00000008 on the next cycle; with en=0, out SHALL be 0 on the next cycle.
REQ-030 With en=1, in=31 and no sweep, out SHALL be 0x80000000 on the next cycle.
REQ-031 A sweep_start pulse SHALL make busy high 31 cycles, out walk 0x1 through 0x40000000, then done high 1 cycle with out=0; bit 31 never set.
REQ-032 With sweep_start=1, en=1 and in=7 in the same IDLE cycle, out SHALL be 0x00000001 next (sweep wins); a second sweep_start at sweep cycle 10 SHALL leave the total busy count at 31.
REQ-033 reset=1 at sweep cycle 12 SHALL give out=0, busy=0 and done=0 on the next cycle, with no done pulse afterwards.
REQ-034 With SEL_W=2 and SKIP_TOP=0, a sweep SHALL make out walk 0x1, 0x2, 0x4, 0x8 with busy high 4 cycles, followed by a done pulse.
